dsp_result_checker: RTL

Synthesizable result-receiving end of the DSP_top operand interface. Sits on DSP_top's `out` bus and is driven by the same `start`/`mode`/`pipe_stages` controls as the DSP. At issue time it queues an expected result supplied by a golden source (on-chip model or host). It then samples `out` exactly when the DSP result is due, compares the two, and keeps match/error statistics for on-silicon self-test.

---
 rtl/dsp_chk_pkg.sv | 31 +++
 rtl/dsp_chk_fifo.sv | 54 +++++
 rtl/dsp_result_checker.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dsp_chk_pkg.sv
// Shared constants and helpers for the DSP result checker.
// Latency lookup, mode encodings and a saturating counter step.
package dsp_chk_pkg;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } dsp_mode_e;

  // Extra result latency added by each DSP mode; mode 3 behaves as mode 2.
  localparam logic [1:0] EXTRA_LAT [4] = '{2'd0, 2'd1, 2'd3, 2'd3};

  function automatic logic [1:0] mode_extra(input logic [1:0] mode);
    return EXTRA_LAT[mode];
  endfunction

  // Longest possible latency: largest pipe_stages plus the largest mode extra.
  function automatic int max_lat(input int base_latency, input int pipe_stage_width);
    return base_latency + (1 << pipe_stage_width) + 2;
  endfunction

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (value >= max_v) ? max_v : value + 32'd1;
  endfunction

endpackage

// File: rtl/dsp_chk_fifo.sv
// Synchronous FIFO for expected results; a push into a full FIFO is
// accepted when a pop happens at the same edge.
module dsp_chk_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !(rst || flush)) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dsp_result_checker.sv
// Compares DSP_top results against queued expected values at the DSP latency.
// Define DSP_CHK_FIRST_ERR_EN to build the first-mismatch capture registers.
module dsp_result_checker
  import dsp_chk_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int PIPE_STAGE_WIDTH = 2,
  parameter int BASE_LATENCY     = 2,
  parameter int FIFO_DEPTH       = 8,
  parameter int CNT_W            = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [PIPE_STAGE_WIDTH-1:0] pipe_stages,
  input  logic [2*WIDTH-1:0]          exp_data,
  input  logic [2*WIDTH-1:0]          out,
  input  logic                        clear,
  output logic                        busy,
  output logic [CNT_W-1:0]            match_count,
  output logic [CNT_W-1:0]            error_count,
  output logic                        mismatch,
  output logic                        overflow,
  output logic                        cfg_err,
  output logic [2*WIDTH-1:0]          first_err_out,
  output logic [2*WIDTH-1:0]          first_err_exp
);

  localparam int ML = max_lat(BASE_LATENCY, PIPE_STAGE_WIDTH);
  localparam int LW = $clog2(ML + 1);

  // dl_q[k] set: a token was issued k edges ago and has not yet been compared.
  logic [ML:1]                 dl_q;
  logic [ML:1]                 dl_shift;
  logic [LW-1:0]               lat_q;
  logic [LW-1:0]               lat_now;
  dsp_mode_e                   mode_q;
  logic [PIPE_STAGE_WIDTH-1:0] ps_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [2*WIDTH-1:0] head;
  logic               cfg_chg;
  logic               flush;
  logic               pop;
  logic               accept;
  logic               drop;
  logic               miss;
  logic [CNT_W-1:0]   match_inc;
  logic [CNT_W-1:0]   error_inc;

  assign lat_now = LW'(BASE_LATENCY + int'(pipe_stages) + int'(mode_extra(mode)));

  assign busy    = !fifo_empty || (|dl_q);
  assign cfg_chg = busy && ((mode != mode_q) || (pipe_stages != ps_q));
  assign flush   = clear || cfg_chg;
  assign pop     = dl_q[lat_q] && !flush;
  assign accept  = start && !flush && (!fifo_full || pop);
  assign drop    = start && !flush && fifo_full && !pop;
  assign miss    = pop && (out != head);

  assign match_inc = CNT_W'(sat_inc(32'(match_count), CNT_W));
  assign error_inc = CNT_W'(sat_inc(32'(error_count), CNT_W));

  // Tokens are dropped once they pass the tap so busy falls right after the last compare.
  always_comb begin
    dl_shift    = '0;
    dl_shift[1] = accept;
    for (int k = 2; k <= ML; k++) begin
      dl_shift[k] = dl_q[k-1] && ((k - 1) < int'(lat_q));
    end
  end

  dsp_chk_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (accept),
    .pop   (pop),
    .wdata (exp_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q        <= '0;
      match_count <= '0;
      error_count <= '0;
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
      cfg_err     <= 1'b0;
      mode_q      <= MODE_0;
      ps_q        <= '0;
      lat_q       <= LW'(BASE_LATENCY);
    end else if (clear) begin
      dl_q        <= '0;
      match_count <= '0;
      error_count <= '0;
      mismatch    <= 1'b0;
      overflow    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      dl_q     <= cfg_chg ? '0 : dl_shift;
      mismatch <= miss;
      if (pop && !miss) match_count <= match_inc;
      if (miss)         error_count <= error_inc;
      if (drop)         overflow    <= 1'b1;
      if (cfg_chg)      cfg_err     <= 1'b1;
      // Configuration is only latched when the first issue after idle arrives.
      if (accept && !busy) begin
        mode_q <= dsp_mode_e'(mode);
        ps_q   <= pipe_stages;
        lat_q  <= lat_now;
      end
    end
  end

`ifdef DSP_CHK_FIRST_ERR_EN
  logic err_seen;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      err_seen      <= 1'b0;
      first_err_out <= '0;
      first_err_exp <= '0;
    end else if (miss && !err_seen) begin
      err_seen      <= 1'b1;
      first_err_out <= out;
      first_err_exp <= head;
    end
  end
`else
  assign first_err_out = '0;
  assign first_err_exp = '0;
`endif

endmodule
